// File: rtl/frame_streamer_pkg.sv
// Shared video constants, RGB field positions and streamer state encoding.
// The filter reuses FRAME_W for its delayed write-back offset.
package frame_streamer_pkg;

    localparam int FRAME_W   = 320;
    localparam int FRAME_H   = 240;
    localparam int FRAME_PIX = FRAME_W * FRAME_H;

    localparam int CH_W  = 8;
    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } stream_state_t;

endpackage

// File: rtl/frame_streamer_if.sv
// Handshake bundle between the frame streamer, its source RAM and the filter.
interface frame_streamer_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 24
);
    logic              start;
    logic              loop;
    logic              ready;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_q;
    logic [ADDR_W-1:0] out_addr;
    logic [PIX_W-1:0]  out_data;
    logic              out_en;
    logic              sof;
    logic              eof;
    logic              busy;

    modport master (
        input  start, loop, ready, ram_q,
        output ram_rd, ram_addr, out_addr, out_data, out_en, sof, eof, busy
    );

    modport slave (
        output start, loop, ready, ram_q,
        input  ram_rd, ram_addr, out_addr, out_data, out_en, sof, eof, busy
    );
endinterface

// File: rtl/frame_streamer_pix_fifo2.sv
// Two-entry FIFO of {address, pixel}; push and pop together while full is legal.
module pix_fifo2 #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // When full, wr_ptr equals rd_ptr, so a push+pop overwrites the slot being popped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/frame_streamer.sv
// Raster pixel source: reads a frame from RAM and presents it one pixel per
// transfer, absorbing RAM latency and downstream backpressure.
//
//   state     | meaning
//   ST_IDLE   | waiting for start, read pointer at 0
//   ST_STREAM | issuing reads; wraps to 0 at frame end when loop is set
//   ST_DRAIN  | all reads issued, emptying FIFO until the eof transfer
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int WIDTH  = FRAME_W,
    parameter int HEIGHT = FRAME_H,
    parameter int ADDR_W = $clog2(FRAME_PIX),
    parameter int PIX_W  = 24
) (
    input logic              clk,
    input logic              reset,
    frame_streamer_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    stream_state_t             state, state_nx;
    logic [ADDR_W-1:0]         rp;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      inflight;
    logic                      rd;
    logic                      xfer;
    logic [1:0]                count;
    logic [2:0]                pending;
    logic [ADDR_W+PIX_W-1:0]   head;
    logic [ADDR_W-1:0]         head_addr;

    assign head_addr = head[PIX_W +: ADDR_W];
    assign pending   = {1'b0, count} + {2'b00, inflight};
    assign xfer      = (count != 2'd0) && bus.ready;
    // A transfer this cycle frees a slot, so the bound is relaxed by out_en.
    assign rd        = (state == ST_STREAM) && (pending < (3'd2 + {2'b00, xfer}));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nx = ST_STREAM;
            ST_STREAM: if (rd && (rp == LAST) && !bus.loop) state_nx = ST_DRAIN;
            ST_DRAIN:  if (xfer && (head_addr == LAST)) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rp       <= '0;
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= rd;
            if (rd) begin
                rd_addr <= rp;
                rp      <= (rp == LAST) ? '0 : rp + 1'b1;
            end
        end
    end

    pix_fifo2 #(.W(ADDR_W + PIX_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (xfer),
        .din   ({rd_addr, bus.ram_q}),
        .dout  (head),
        .count (count)
    );

    assign bus.ram_rd   = rd;
    assign bus.ram_addr = rp;
    assign bus.out_addr = head_addr;
    assign bus.out_data = head[PIX_W-1:0];
    assign bus.out_en   = xfer;
    assign bus.sof      = xfer && (head_addr == '0);
    assign bus.eof      = xfer && (head_addr == LAST);
    assign bus.busy     = (state != ST_IDLE);
endmodule
